// File: rtl/vga_text_controller_if.sv
// rtl/vga_text_controller_if.sv - memory read ports and palette write port of the text-mode VGA engine
// master = controller side, slave = text RAM / font ROM / host side.
interface vga_text_controller_if #(
   parameter int ADDR_W = 11,
   parameter int ROW_W  = 5,
   parameter int CHAR_W = 10
);
   logic [ADDR_W-1:0]  txt_addr;
   logic [15:0]        txt_data;
   logic [8+ROW_W-1:0] font_addr;
   logic [CHAR_W-1:0]  font_data;
   logic               pal_we;
   logic [3:0]         pal_idx;
   logic [23:0]        pal_data;

   modport master (
      output txt_addr, font_addr,
      input  txt_data, font_data, pal_we, pal_idx, pal_data
   );

   modport slave (
      input  txt_addr, font_addr,
      output txt_data, font_data, pal_we, pal_idx, pal_data
   );
endinterface

// File: rtl/vga_text_controller.sv
// rtl/vga_text_controller.sv - text-mode VGA engine: timing, 4-stage pixel pipeline, palette, blinking cursor
// Text RAM and font ROM are external with one CLOCK_50 read latency.
module vga_text_controller #(
   parameter int CLK_DIV      = 2,
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int CHAR_W       = 10,
   parameter int CHAR_H       = 20,
   parameter int COLS         = 64,
   parameter int ROWS         = 24,
   parameter int ADDR_W       = 11,
   parameter int ROW_W        = 5,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   vga_text_controller_if.master bus,
   input  logic                  cursor_en,
   input  logic [5:0]            cursor_col,
   input  logic [4:0]            cursor_row,
   output logic                  frame_start,
   output logic                  VGA_CLK,
   output logic [7:0]            VGA_R,
   output logic [7:0]            VGA_G,
   output logic [7:0]            VGA_B,
   output logic                  VGA_HS,
   output logic                  VGA_VS,
   output logic                  VGA_BLANK_N,
   output logic                  VGA_SYNC_N
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW  = $clog2(H_TOTAL);
   localparam int VW  = $clog2(V_TOTAL);
   localparam int UW  = $clog2(CHAR_W);
   localparam int VCW = $clog2(CHAR_H);
   localparam int CW  = $clog2(H_TOTAL / CHAR_W + 2);
   localparam int RW  = $clog2(V_TOTAL / CHAR_H + 2);
   localparam int DW  = $clog2(CLK_DIV);
   localparam int BW  = $clog2(BLINK_FRAMES + 1);

   function automatic logic [23:0] pal_default(input logic [3:0] i);
      case (i)
         4'd0:    pal_default = 24'h090300;
         4'd1:    pal_default = 24'hDB2D20;
         4'd2:    pal_default = 24'h01A252;
         4'd3:    pal_default = 24'hFDED02;
         4'd4:    pal_default = 24'h01A0E4;
         4'd5:    pal_default = 24'hA16A94;
         4'd6:    pal_default = 24'hB5E4F4;
         4'd7:    pal_default = 24'hA5A2A2;
         4'd8:    pal_default = 24'h5C5855;
         4'd9:    pal_default = 24'hE8BBD0;
         4'd10:   pal_default = 24'h3A3432;
         4'd11:   pal_default = 24'h4A4543;
         4'd12:   pal_default = 24'h807D7C;
         4'd13:   pal_default = 24'hD6D5D4;
         4'd14:   pal_default = 24'hCDAB53;
         default: pal_default = 24'hF7F7F7;
      endcase
   endfunction

   logic [DW-1:0] ce_cnt;
   logic [DW-1:0] ce_nxt;
   logic          pix_ce;

   assign pix_ce = (ce_cnt == DW'(CLK_DIV - 1));
   assign ce_nxt = pix_ce ? '0 : ce_cnt + DW'(1);

   // VGA_CLK rises halfway through each pixel so the DAC samples stable data
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         ce_cnt  <= '0;
         VGA_CLK <= 1'b0;
      end else begin
         ce_cnt  <= ce_nxt;
         VGA_CLK <= (32'(ce_nxt) >= CLK_DIV / 2);
      end
   end

   logic [HW-1:0]  h;
   logic [VW-1:0]  v;
   logic [UW-1:0]  u;
   logic [VCW-1:0] cv;
   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic           h_wrap;
   logic           v_wrap;

   assign h_wrap = (h == HW'(H_TOTAL - 1));
   assign v_wrap = (v == VW'(V_TOTAL - 1));

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         h   <= '0;
         v   <= '0;
         u   <= '0;
         cv  <= '0;
         col <= '0;
         row <= '0;
      end else if (pix_ce) begin
         if (h_wrap) begin
            h   <= '0;
            u   <= '0;
            col <= '0;
            if (v_wrap) begin
               v   <= '0;
               cv  <= '0;
               row <= '0;
            end else begin
               v <= v + VW'(1);
               if (cv == VCW'(CHAR_H - 1)) begin
                  cv  <= '0;
                  row <= row + RW'(1);
               end else begin
                  cv <= cv + VCW'(1);
               end
            end
         end else begin
            h <= h + HW'(1);
            if (u == UW'(CHAR_W - 1)) begin
               u   <= '0;
               col <= col + CW'(1);
            end else begin
               u <= u + UW'(1);
            end
         end
      end
   end

   logic act;
   logic hs_raw;
   logic vs_raw;
   logic in_grid;

   assign act         = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
   assign hs_raw      = !((32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw      = !((32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC));
   assign in_grid     = act && (32'(col) < COLS) && (32'(row) < ROWS);
   assign frame_start = pix_ce && (h == '0) && (v == '0);

   logic [ADDR_W-1:0]  txt_addr_q;
   logic [8+ROW_W-1:0] font_addr_q;
   logic               s0_act, s0_grid, s0_hs, s0_vs;
   logic [UW-1:0]      s0_u;
   logic [VCW-1:0]     s0_v;
   logic [CW-1:0]      s0_col;
   logic [RW-1:0]      s0_row;
   logic               s1_act, s1_grid, s1_hs, s1_vs, s1_cur, cur_hold;
   logic [UW-1:0]      s1_u;
   logic [7:0]         s1_attr;
   logic               s2_act, s2_grid, s2_hs, s2_vs;
   logic [UW-1:0]      s2_u;
   logic [CHAR_W-1:0]  s2_bits;
   logic [3:0]         s2_fg, s2_bg;
   logic [23:0]        rgb;
   logic               blink_phase;
   logic [BW-1:0]      blink_cnt;
   logic [23:0]        palette [16];

   assign bus.txt_addr  = txt_addr_q;
   assign bus.font_addr = font_addr_q;

   // Cursor hit is latched on the first pixel of a cell and held for the rest of it
   logic cur_fresh;
   logic cur_cell;
   assign cur_fresh = cursor_en && (32'(s0_col) == 32'(cursor_col)) && (32'(s0_row) == 32'(cursor_row));
   assign cur_cell  = (s0_u == '0) ? cur_fresh : cur_hold;

   logic [UW-1:0] bit_sel;
   logic [3:0]    pix_idx;
   assign bit_sel = UW'(CHAR_W - 1) - s2_u;
   assign pix_idx = !s2_grid ? 4'd0 : (s2_bits[bit_sel] ? s2_fg : s2_bg);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         txt_addr_q  <= '0;
         font_addr_q <= '0;
         s0_act <= 1'b0; s0_grid <= 1'b0; s0_hs <= 1'b1; s0_vs <= 1'b1;
         s0_u   <= '0;   s0_v    <= '0;   s0_col <= '0;  s0_row <= '0;
         s1_act <= 1'b0; s1_grid <= 1'b0; s1_hs <= 1'b1; s1_vs <= 1'b1;
         s1_u   <= '0;   s1_attr <= '0;   s1_cur <= 1'b0; cur_hold <= 1'b0;
         s2_act <= 1'b0; s2_grid <= 1'b0; s2_hs <= 1'b1; s2_vs <= 1'b1;
         s2_u   <= '0;   s2_bits <= '0;   s2_fg  <= '0;  s2_bg  <= '0;
         rgb         <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else if (pix_ce) begin
         if (in_grid)
            txt_addr_q <= ADDR_W'(32'(row) * COLS + 32'(col));
         s0_act <= act;  s0_grid <= in_grid; s0_hs <= hs_raw; s0_vs <= vs_raw;
         s0_u   <= u;    s0_v    <= cv;      s0_col <= col;   s0_row <= row;

         if (s0_grid)
            font_addr_q <= {bus.txt_data[7:0], ROW_W'(s0_v)};
         s1_act  <= s0_act; s1_grid <= s0_grid; s1_hs <= s0_hs; s1_vs <= s0_vs;
         s1_u    <= s0_u;
         s1_attr <= bus.txt_data[15:8];
         s1_cur  <= cur_cell;
         cur_hold <= cur_cell;

         s2_act  <= s1_act; s2_grid <= s1_grid; s2_hs <= s1_hs; s2_vs <= s1_vs;
         s2_u    <= s1_u;
         s2_bits <= bus.font_data;
         s2_fg   <= (s1_cur && blink_phase) ? s1_attr[7:4] : s1_attr[3:0];
         s2_bg   <= (s1_cur && blink_phase) ? s1_attr[3:0] : s1_attr[7:4];

         rgb         <= s2_act ? palette[pix_idx] : 24'd0;
         VGA_HS      <= s2_hs;
         VGA_VS      <= s2_vs;
         VGA_BLANK_N <= s2_act;
      end
   end

   // The first frame_start after reset only primes the count, so phase 1 begins with frame BLINK_FRAMES
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == BW'(BLINK_FRAMES)) begin
            blink_cnt   <= BW'(1);
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < 16; i++)
            palette[i] <= pal_default(4'(i));
      end else if (bus.pal_we) begin
         palette[bus.pal_idx] <= bus.pal_data;
      end
   end

   assign VGA_R      = rgb[23:16];
   assign VGA_G      = rgb[15:8];
   assign VGA_B      = rgb[7:0];
   assign VGA_SYNC_N = 1'b1;
endmodule

// File: tb/tb_vga_text_controller.sv
// tb/tb_vga_text_controller.sv - directed bench on a reduced 56x36 timing, 3x2 grid, 2-frame blink
// Pixels are sampled once per VGA_CLK period and located relative to frame_start.
module tb_vga_text_controller;
   localparam int HT    = 56;
   localparam int VT    = 36;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cursor_en;
   logic [5:0] cursor_col;
   logic [4:0] cursor_row;
   logic       frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
   logic [7:0] vga_r, vga_g, vga_b;

   vga_text_controller_if #(.ADDR_W(11), .ROW_W(5), .CHAR_W(10)) bus ();

   vga_text_controller #(
      .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .CHAR_W(10), .CHAR_H(10), .COLS(3), .ROWS(2),
      .ADDR_W(11), .ROW_W(5), .BLINK_FRAMES(2)
   ) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .bus(bus),
      .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .frame_start(frame_start), .VGA_CLK(vga_clk),
      .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n)
   );

   always #5 clk = ~clk;

   logic [15:0] txt_mem [0:2047];

   function automatic logic [9:0] glyph(input logic [7:0] code, input logic [4:0] r);
      if (code == 8'h41)
         return (r == 5'd0) ? 10'b1100110010 : 10'b0000000001;
      return 10'b0;
   endfunction

   always @(posedge clk) bus.txt_data  <= txt_mem[bus.txt_addr];
   always @(posedge clk) bus.font_data <= glyph(bus.font_addr[12:5], bus.font_addr[4:0]);

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   int pos, cur_pos, fcount, npix, period1, period2, max_addr;
   int hs_first, hs_cnt, vs_first, vs_cnt;
   logic vclk_q;
   logic bl39, bl40, bly29, bly30;
   logic [23:0] px40, px10, px30, pxr20, l1x0, l1x9;
   logic [23:0] cap0 [0:15][0:9];
   logic [23:0] cur_rgb [0:15];

   initial begin
      max_addr = 0; hs_cnt = 0; vs_cnt = 0; hs_first = -1; vs_first = -1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         pos = -3; cur_pos = -100; fcount = 0; npix = 0; vclk_q = 1'b0;
      end else begin
         if (vga_clk && !vclk_q && fcount > 0) begin
            if (pos >= 0 && fcount < 16) begin
               automatic int x = pos % HT;
               automatic int y = pos / HT;
               automatic logic [23:0] rgb = {vga_r, vga_g, vga_b};
               if (fcount == 1) begin
                  if (y == 0 && !vga_hs) begin
                     if (hs_cnt == 0) hs_first = x;
                     hs_cnt++;
                  end
                  if (x == 0 && !vga_vs) begin
                     if (vs_cnt == 0) vs_first = y;
                     vs_cnt++;
                  end
                  if (y == 0 && x == 39) bl39 = vga_blank_n;
                  if (y == 0 && x == 40) begin bl40 = vga_blank_n; px40 = rgb; end
                  if (y == 29 && x == 0) bly29 = vga_blank_n;
                  if (y == 30 && x == 0) bly30 = vga_blank_n;
                  if (y == 0 && x == 10) px10 = rgb;
                  if (y == 0 && x == 30) px30 = rgb;
                  if (y == 20 && x == 5) pxr20 = rgb;
                  if (y == 1 && x == 0) l1x0 = rgb;
                  if (y == 1 && x == 9) l1x9 = rgb;
               end
               if (y == 0 && x < 10) cap0[fcount][x] = rgb;
               if (y == 15 && x == 25) cur_rgb[fcount] = rgb;
            end
            cur_pos = pos;
            pos++;
            npix++;
         end
         vclk_q = vga_clk;
         if (frame_start) begin
            if (fcount == 1) period1 = npix;
            if (fcount == 2) period2 = npix;
            npix = 0;
            pos = -3;
            fcount++;
         end
         if (int'(bus.txt_addr) > max_addr) max_addr = int'(bus.txt_addr);
      end
   end

   task automatic wait_until(input int f, input int p, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(posedge clk); #1;
         if (fcount == f && (p < 0 || cur_pos == p)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int k;
      logic [9:0] pat;
      logic [23:0] expv;
      rst_n = 1'b0;
      cursor_en = 1'b1; cursor_col = 6'd2; cursor_row = 5'd1;
      bus.pal_we = 1'b0; bus.pal_idx = 4'd0; bus.pal_data = 24'd0;
      for (int i = 0; i < 2048; i++) txt_mem[i] = 16'h3441;
      txt_mem[0] = 16'h1F41;
      txt_mem[5] = 16'h2F20;
      repeat (5) @(posedge clk);
      #1;
      check_val("rst_hs", vga_hs, 1);
      check_val("rst_vs", vga_vs, 1);
      check_val("rst_blank_n", vga_blank_n, 0);
      check_val("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      check_val("rst_vga_clk", vga_clk, 0);
      check_val("rst_frame_start", frame_start, 0);
      check_val("rst_txt_addr", bus.txt_addr, 0);
      check_val("rst_font_addr", bus.font_addr, 0);
      check_val("sync_n", vga_sync_n, 1);
      rst_n = 1'b1;

      wait_until(3, -1, ok);
      check_val("reach_frame2", ok, 1);
      check_val("frame_period1", period1, FRAME);
      check_val("frame_period2", period2, FRAME);
      check_val("hs_first_px", hs_first, 44);
      check_val("hs_low_px", hs_cnt, 6);
      check_val("vs_first_line", vs_first, 32);
      check_val("vs_low_lines", vs_cnt, 2);
      check_val("blank_x39", bl39, 1);
      check_val("blank_x40", bl40, 0);
      check_val("blank_y29", bly29, 1);
      check_val("blank_y30", bly30, 0);
      check_val("rgb_hblank", px40, 0);
      pat = 10'b1100110010;
      for (int x = 0; x < 10; x++) begin
         expv = pat[9-x] ? 24'hF7F7F7 : 24'hDB2D20;
         check_val($sformatf("cell0_row0_x%0d", x), cap0[1][x], expv);
      end
      check_val("cell0_row1_x0", l1x0, 24'hDB2D20);
      check_val("cell0_row1_x9", l1x9, 24'hF7F7F7);
      check_val("cell1_x10", px10, 24'h01A0E4);
      check_val("off_grid_col", px30, 24'h090300);
      check_val("off_grid_row", pxr20, 24'h090300);

      wait_until(6, 3, ok);
      check_val("reach_pal_point", ok, 1);
      bus.pal_we = 1'b1; bus.pal_idx = 4'd1; bus.pal_data = 24'h123456;
      @(posedge clk); #1;
      bus.pal_we = 1'b0;
      check_val("cursor_f0", cur_rgb[1], 24'h01A252);
      check_val("cursor_f1", cur_rgb[2], 24'h01A252);
      check_val("cursor_f2", cur_rgb[3], 24'hF7F7F7);
      check_val("cursor_f3", cur_rgb[4], 24'hF7F7F7);
      check_val("cursor_f4", cur_rgb[5], 24'h01A252);

      wait_until(7, 20, ok);
      check_val("reach_rst_point", ok, 1);
      check_val("pal_old_x2", cap0[6][2], 24'hDB2D20);
      check_val("pal_old_x3", cap0[6][3], 24'hDB2D20);
      check_val("pal_new_x6", cap0[6][6], 24'h123456);
      check_val("pal_new_x7", cap0[6][7], 24'h123456);
      check_val("pal_new_x9", cap0[6][9], 24'h123456);
      check_val("pal_fg_x4", cap0[6][4], 24'hF7F7F7);
      check_val("txt_addr_max", max_addr, 5);
      check_val("pre_rst_rgb", {vga_r, vga_g, vga_b}, 24'h01A0E4);
      check_val("pre_rst_blank_n", vga_blank_n, 1);

      rst_n = 1'b0;
      #1;
      check_val("arst_rgb", {vga_r, vga_g, vga_b}, 0);
      check_val("arst_blank_n", vga_blank_n, 0);
      check_val("arst_hs", vga_hs, 1);
      check_val("arst_vs", vga_vs, 1);
      check_val("arst_vga_clk", vga_clk, 0);
      check_val("arst_txt_addr", bus.txt_addr, 0);
      check_val("arst_font_addr", bus.font_addr, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (frame_start) begin
            k = i;
            break;
         end
      end
      check_val("fs_after_rst", k, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
